// File: rtl/input_cmd_scheduler_if.sv
// Command stream between the scheduler and the game FSM: show-ahead head,
// valid/ready handshake and the queue occupancy.
interface input_cmd_scheduler_if #(
    parameter int CMD_W = 4,
    parameter int DEPTH = 16
) ();
    logic                   cmd_valid_o;
    logic [CMD_W-1:0]       cmd_o;
    logic                   cmd_ready_i;
    logic [$clog2(DEPTH):0] level_o;

    modport master (output cmd_valid_o, output cmd_o, output level_o, input cmd_ready_i);
    modport slave  (input cmd_valid_o, input cmd_o, input level_o, output cmd_ready_i);
endinterface

// File: rtl/input_cmd_scheduler.sv
// Merges event strobes, auto-repeating held buttons and periodic timers into one
// ordered command stream: pending latches -> fixed-priority arbiter -> show-ahead FIFO.
module input_cmd_scheduler #(
    parameter int               CMD_W     = 4,
    parameter int               DEPTH     = 16,
    parameter int               N_EV      = 2,
    parameter int               N_SRC     = 4,
    parameter int               N_TMR     = 2,
    parameter int               TMR_W     = 32,
    parameter int               DAS_DELAY = 12_500_000,
    parameter int               DAS_RATE  = 2_500_000,
    parameter logic [N_SRC-1:0] REPEAT_EN = '1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic                   flush_i,
    input  logic [N_EV-1:0]        ev_valid_i,
    input  logic [N_EV*CMD_W-1:0]  ev_cmd_i,
    input  logic [N_SRC-1:0]       hold_i,
    input  logic [N_SRC*CMD_W-1:0] hold_cmd_i,
    input  logic [N_TMR*TMR_W-1:0] tmr_period_i,
    input  logic [N_TMR*CMD_W-1:0] tmr_cmd_i,
    input_cmd_scheduler_if.master  cmd_if,
    output logic [15:0]            coalesce_cnt_o
);
    localparam int R  = N_EV + N_SRC + N_TMR;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N_SRC-1:0] r_hold_prev;
    logic [31:0]      r_rep_cnt   [N_SRC];
    logic [N_SRC-1:0] r_rep_phase;
    logic [TMR_W-1:0] r_tmr_cnt   [N_TMR];
    logic [R-1:0]     r_pend;
    logic [CMD_W-1:0] r_pend_cmd  [R];
    logic [15:0]      r_coal;
    logic [CMD_W-1:0] r_mem       [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic [N_SRC-1:0] w_press;
    logic [N_SRC-1:0] w_rep_fire;
    logic [N_TMR-1:0] w_tmr_fire;
    logic [R-1:0]     w_req;
    logic [CMD_W-1:0] w_req_cmd   [R];
    logic [R-1:0]     w_gnt;
    logic             w_gnt_vld;
    logic [CMD_W-1:0] w_push_cmd;
    logic             w_valid;
    logic             w_pop;
    logic             w_push_ok;
    logic [R-1:0]     w_merge;
    logic [16:0]      w_coal_sum;

    assign w_valid   = (r_level != '0);
    assign w_pop     = w_valid && cmd_if.cmd_ready_i;
    assign w_push_ok = (r_level < LW'(DEPTH)) || w_pop;

    // Request generation; repeat phase 0 waits DAS_DELAY, phase 1 waits DAS_RATE
    always_comb begin
        w_req = '0;
        for (int i = 0; i < R; i++) w_req_cmd[i] = '0;
        w_press = hold_i & ~r_hold_prev;
        for (int k = 0; k < N_SRC; k++)
            w_rep_fire[k] = hold_i[k] && !w_press[k] &&
                            (r_rep_phase[k] ? (r_rep_cnt[k] == 32'(DAS_RATE))
                                            : (r_rep_cnt[k] == 32'(DAS_DELAY)));
        for (int k = 0; k < N_TMR; k++)
            w_tmr_fire[k] = (tmr_period_i[k*TMR_W +: TMR_W] != '0) &&
                            (r_tmr_cnt[k] >= tmr_period_i[k*TMR_W +: TMR_W] - TMR_W'(1));
        if (enable_i && !flush_i) begin
            for (int k = 0; k < N_EV; k++) begin
                w_req[k]     = ev_valid_i[k];
                w_req_cmd[k] = ev_cmd_i[k*CMD_W +: CMD_W];
            end
            for (int k = 0; k < N_SRC; k++) begin
                w_req[N_EV+k]     = w_press[k] || (REPEAT_EN[k] && w_rep_fire[k]);
                w_req_cmd[N_EV+k] = hold_cmd_i[k*CMD_W +: CMD_W];
            end
            for (int k = 0; k < N_TMR; k++) begin
                w_req[N_EV+N_SRC+k]     = w_tmr_fire[k];
                w_req_cmd[N_EV+N_SRC+k] = tmr_cmd_i[k*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        w_gnt      = '0;
        w_gnt_vld  = 1'b0;
        w_push_cmd = '0;
        if (w_push_ok && !flush_i) begin
            for (int i = 0; i < R; i++) begin
                if (r_pend[i] && !w_gnt_vld) begin
                    w_gnt[i]   = 1'b1;
                    w_gnt_vld  = 1'b1;
                    w_push_cmd = r_pend_cmd[i];
                end
            end
        end
    end

    assign w_merge    = w_req & r_pend & ~w_gnt;
    assign w_coal_sum = {1'b0, r_coal} + 17'($countones(w_merge));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_prev <= '0;
            r_rep_phase <= '0;
            for (int k = 0; k < N_SRC; k++) r_rep_cnt[k] <= '0;
            for (int k = 0; k < N_TMR; k++) r_tmr_cnt[k] <= '0;
        end else begin
            // Edge detector samples even while disabled so a held button never looks pressed
            r_hold_prev <= hold_i;
            for (int k = 0; k < N_SRC; k++) begin
                if (flush_i || !enable_i || !hold_i[k]) begin
                    r_rep_cnt[k]   <= '0;
                    r_rep_phase[k] <= 1'b0;
                end else if (w_press[k]) begin
                    r_rep_cnt[k]   <= 32'd1;
                    r_rep_phase[k] <= 1'b0;
                end else if (w_rep_fire[k]) begin
                    r_rep_cnt[k]   <= 32'd1;
                    r_rep_phase[k] <= 1'b1;
                end else begin
                    r_rep_cnt[k]   <= r_rep_cnt[k] + 32'd1;
                end
            end
            for (int k = 0; k < N_TMR; k++) begin
                if (flush_i || !enable_i || (tmr_period_i[k*TMR_W +: TMR_W] == '0) || w_tmr_fire[k])
                    r_tmr_cnt[k] <= '0;
                else
                    r_tmr_cnt[k] <= r_tmr_cnt[k] + TMR_W'(1);
            end
        end
    end

    // Pending latches: a new request outranks the grant-clear of the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_coal <= '0;
        end else begin
            r_coal <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
            if (flush_i) begin
                r_pend <= '0;
            end else begin
                for (int i = 0; i < R; i++) begin
                    if (w_req[i])      r_pend[i] <= 1'b1;
                    else if (w_gnt[i]) r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < R; i++)
            if (w_req[i]) r_pend_cmd[i] <= w_req_cmd[i];
        if (w_gnt_vld) r_mem[r_wr_ptr] <= w_push_cmd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_gnt_vld) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_gnt_vld, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head is forced to zero while empty so it is stable and clean out of reset
    assign cmd_if.cmd_valid_o = w_valid;
    assign cmd_if.cmd_o       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign cmd_if.level_o     = r_level;
    assign coalesce_cnt_o     = r_coal;
endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Bench for input_cmd_scheduler: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_input_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int DAS_D = 10;
    localparam int DAS_R = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable_i;
    logic        flush_i;
    logic [1:0]  ev_valid;
    logic [7:0]  ev_cmd;
    logic [3:0]  hold;
    logic [15:0] hold_cmd;
    logic [63:0] tmr_period;
    logic [7:0]  tmr_cmd;
    logic [15:0] coal_o;

    input_cmd_scheduler_if #(.CMD_W(4), .DEPTH(DEPTH)) cmd_if ();

    input_cmd_scheduler #(
        .CMD_W(4), .DEPTH(DEPTH), .N_EV(2), .N_SRC(4), .N_TMR(2), .TMR_W(32),
        .DAS_DELAY(DAS_D), .DAS_RATE(DAS_R)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .flush_i(flush_i),
        .ev_valid_i(ev_valid), .ev_cmd_i(ev_cmd), .hold_i(hold), .hold_cmd_i(hold_cmd),
        .tmr_period_i(tmr_period), .tmr_cmd_i(tmr_cmd), .cmd_if(cmd_if),
        .coalesce_cnt_o(coal_o)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int     q[$];
    bit     m_pend[8];
    int     m_pcmd[8];
    bit     m_hprev[4];
    int     m_age[4];
    longint m_tcnt[2];
    int     m_coal;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_pcmd[i] = 0; end
        for (int k = 0; k < 4; k++) begin m_hprev[k] = 0; m_age[k] = 0; end
        for (int k = 0; k < 2; k++) m_tcnt[k] = 0;
        m_coal = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit     req[8];
        int     rc[8];
        bit     pop, tfire[2];
        int     g;
        longint per[2];
        pop = (q.size() > 0) && cmd_if.cmd_ready_i;
        for (int i = 0; i < 8; i++) begin req[i] = 0; rc[i] = 0; end
        for (int k = 0; k < 2; k++) begin
            per[k]   = longint'(tmr_period[k*32 +: 32]);
            tfire[k] = (per[k] != 0) && (m_tcnt[k] >= per[k] - 1);
        end
        if (enable_i && !flush_i) begin
            for (int k = 0; k < 2; k++)
                if (ev_valid[k]) begin req[k] = 1; rc[k] = int'(ev_cmd[k*4 +: 4]); end
            for (int k = 0; k < 4; k++) begin
                bit press, rep;
                press = hold[k] && !m_hprev[k];
                rep   = hold[k] && !press &&
                        (m_age[k] == DAS_D || (m_age[k] > DAS_D && (m_age[k] - DAS_D) % DAS_R == 0));
                if (press || rep) begin req[2+k] = 1; rc[2+k] = int'(hold_cmd[k*4 +: 4]); end
            end
            for (int k = 0; k < 2; k++)
                if (tfire[k]) begin req[6+k] = 1; rc[6+k] = int'(tmr_cmd[k*4 +: 4]); end
        end
        g = -1;
        if (!flush_i && (q.size() < DEPTH || pop))
            for (int i = 0; i < 8; i++) if (m_pend[i] && g < 0) g = i;
        if (flush_i) begin
            q.delete();
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            for (int k = 0; k < 4; k++) m_age[k] = 0;
            for (int k = 0; k < 2; k++) m_tcnt[k] = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (g >= 0) begin q.push_back(m_pcmd[g]); m_pend[g] = 0; end
            for (int i = 0; i < 8; i++)
                if (req[i]) begin
                    if (m_pend[i] && m_coal < 16'hFFFF) m_coal++;
                    m_pend[i] = 1;
                    m_pcmd[i] = rc[i];
                end
            for (int k = 0; k < 4; k++) m_age[k] = (hold[k] && enable_i) ? m_age[k] + 1 : 0;
            for (int k = 0; k < 2; k++)
                m_tcnt[k] = (!enable_i || per[k] == 0 || tfire[k]) ? 0 : m_tcnt[k] + 1;
        end
        for (int k = 0; k < 4; k++) m_hprev[k] = hold[k];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", 32'(cmd_if.cmd_valid_o), 32'(q.size() > 0));
        chk("level", 32'(cmd_if.level_o), 32'(q.size()));
        if (q.size() > 0) chk("head", 32'(cmd_if.cmd_o), 32'(q[0]));
        chk("coal", 32'(coal_o), 32'(m_coal));
    endtask

    task automatic idle_inputs();
        ev_valid = '0; ev_cmd = '0; hold = '0; flush_i = 0;
        tmr_period = '0;
    endtask

    int got[8];
    int offs[$];
    int n, p;

    initial begin
        reset_n = 0; enable_i = 0; cmd_if.cmd_ready_i = 0;
        idle_inputs();
        hold_cmd = 16'h6543; tmr_cmd = 8'h87;
        model_reset();
        #12;
        chk("rst_valid", 32'(cmd_if.cmd_valid_o), 0);
        chk("rst_level", 32'(cmd_if.level_o), 0);
        chk("rst_cmd", 32'(cmd_if.cmd_o), 0);
        chk("rst_coal", 32'(coal_o), 0);
        @(posedge clk); #1;
        reset_n = 1; enable_i = 1;

        // Single event: code 3 on ev0 at cycle 10
        while (cyc < 10) step();
        ev_valid = 2'b01; ev_cmd = 8'h03;
        step();
        ev_valid = '0;
        chk("lat_t1_valid", 32'(cmd_if.cmd_valid_o), 0);
        step();
        chk("lat_t2_valid", 32'(cmd_if.cmd_valid_o), 1);
        chk("lat_t2_cmd", 32'(cmd_if.cmd_o), 3);
        chk("lat_t2_level", 32'(cmd_if.level_o), 1);
        cmd_if.cmd_ready_i = 1; step(); cmd_if.cmd_ready_i = 0;

        // Priority: every line requests in one cycle
        ev_valid = 2'b11; ev_cmd = 8'h21; hold = 4'hF;
        tmr_period = {32'd1, 32'd1};
        step();
        idle_inputs();
        repeat (6) step();
        chk("prio_full", 32'(cmd_if.level_o), DEPTH);
        cmd_if.cmd_ready_i = 1;
        for (int j = 0; j < 8; j++) got[j] = -1;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (cmd_if.cmd_valid_o) begin got[n] = int'(cmd_if.cmd_o); n++; end
            step();
        end
        chk("prio_n", n, 8);
        for (int j = 0; j < 8; j++) chk($sformatf("prio%0d", j), got[j], j + 1);
        chk("prio_coal", 32'(coal_o), 0);

        // Auto-repeat on hold1 (code 4)
        p = cyc; hold = 4'b0010; offs.delete();
        for (int i = 0; i < 34; i++) begin
            if (i == 30) hold = '0;
            step();
            if (cmd_if.cmd_valid_o && cmd_if.cmd_o == 4'h4) offs.push_back(cyc - p - 2);
        end
        chk("rep_n", offs.size(), 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("rep_off%0d", j), (j < offs.size()) ? offs[j] : -1, (j == 0) ? 0 : 6 + 4 * j);
        p = cyc; hold = 4'b0010; offs.delete();
        for (int i = 0; i < 16; i++) begin
            if (i == 14) hold = '0;
            step();
            if (cmd_if.cmd_valid_o && cmd_if.cmd_o == 4'h4) offs.push_back(cyc - p - 2);
        end
        chk("repress_n", offs.size(), 2);
        chk("repress_off1", (offs.size() > 1) ? offs[1] : -1, 10);

        // Full FIFO and coalescing on ev1
        cmd_if.cmd_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            ev_valid = 2'b01; ev_cmd = 8'(i + 1); step();
        end
        ev_valid = '0; step(); step();
        for (int i = 0; i < 3; i++) begin
            ev_valid = 2'b10; ev_cmd = 8'((9 + i) << 4); step();
        end
        ev_valid = '0; step();
        chk("full_level", 32'(cmd_if.level_o), 4);
        chk("full_coal", 32'(coal_o), 2);
        cmd_if.cmd_ready_i = 1;
        for (int j = 0; j < 8; j++) got[j] = -1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            if (cmd_if.cmd_valid_o) begin got[n] = int'(cmd_if.cmd_o); n++; end
            step();
        end
        for (int j = 0; j < 4; j++) chk($sformatf("full_pop%0d", j), got[j], j + 1);
        chk("coal_pop5", got[4], 11);

        // Timer: period 5 for 40 cycles
        tmr_cmd = 8'h09; tmr_period = {32'd0, 32'd5};
        p = cyc; offs.delete();
        for (int i = 0; i < 42; i++) begin
            if (i == 40) tmr_period = '0;
            step();
            if (cmd_if.cmd_valid_o && cmd_if.cmd_o == 4'h9) offs.push_back(cyc - p - 2);
        end
        chk("tmr_n", offs.size(), 8);
        for (int j = 0; j < offs.size(); j++) chk($sformatf("tmr_off%0d", j), offs[j], 4 + 5 * j);
        tmr_period = {32'd0, 32'd5};
        p = cyc; offs.delete();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) tmr_period = {32'd0, 32'd2};
            step();
            if (cmd_if.cmd_valid_o && cmd_if.cmd_o == 4'h9) offs.push_back(cyc - p - 2);
        end
        chk("tmr_shrink", (offs.size() > 0) ? offs[0] : -1, 3);
        tmr_period = '0;
        repeat (3) step();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cmd_if.cmd_valid_o) n++;
        end
        chk("tmr_zero", n, 0);

        // Flush with level 3 and ready high
        cmd_if.cmd_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            ev_valid = 2'b01; ev_cmd = 8'(i + 1); step();
        end
        ev_valid = '0; step(); step();
        chk("flush_pre", 32'(cmd_if.level_o), 3);
        cmd_if.cmd_ready_i = 1; flush_i = 1;
        step();
        flush_i = 0;
        chk("flush_level", 32'(cmd_if.level_o), 0);
        chk("flush_valid", 32'(cmd_if.cmd_valid_o), 0);
        chk("flush_coal", 32'(coal_o), 2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            enable_i = ($urandom_range(0, 19) != 0);
            flush_i  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) ev_valid[k] = ($urandom_range(0, 5) == 0);
            ev_cmd = 8'($urandom);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 11) == 0) hold[k] = ~hold[k];
            if ($urandom_range(0, 15) == 0) hold_cmd = 16'($urandom);
            if ($urandom_range(0, 49) == 0)
                tmr_period = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
            tmr_cmd = 8'($urandom);
            cmd_if.cmd_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset mid-stream
        cmd_if.cmd_ready_i = 0; enable_i = 1; idle_inputs();
        ev_valid = 2'b11; ev_cmd = 8'h5A; step();
        ev_valid = '0; step(); step();
        #2;
        reset_n = 0;
        #1;
        chk("mid_rst_valid", 32'(cmd_if.cmd_valid_o), 0);
        chk("mid_rst_level", 32'(cmd_if.level_o), 0);
        chk("mid_rst_cmd", 32'(cmd_if.cmd_o), 0);
        chk("mid_rst_coal", 32'(coal_o), 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        ev_valid = 2'b10; ev_cmd = 8'h70; step();
        ev_valid = '0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/input_cmd_scheduler.md
Name: input_cmd_scheduler

Overview:
- Parametrised command front-end for the game core. It merges three request classes into one ordered command stream:
  - single-cycle events, such as decoded UART keys and switch edges;
  - held buttons, with auto-repeat;
  - free-running periodic timers, such as gravity and bar injection.
- Requests pass through per-line pending latches and a fixed-priority arbiter into a show-ahead FIFO.
- The game FSM drains the FIFO with a valid/ready handshake.

Parameters:
- CMD_W, 4: command code width.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- N_EV, 2: single-cycle event channels.
- N_SRC, 4: held-button channels.
- N_TMR, 2: periodic timer channels.
- TMR_W, 32: timer period and counter width.
- DAS_DELAY, 12_500_000: cycles from press to the first repeat.
- DAS_RATE, 2_500_000: cycles between subsequent repeats.
- REPEAT_EN, all ones (N_SRC bits): per-hold-channel auto-repeat enable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable_i  in  1  game running; low gates off all request generation.
- flush_i  in  1  synchronous clear of queue and generators.
- ev_valid_i  in  N_EV  one-cycle event strobes.
- ev_cmd_i  in  N_EV*CMD_W  code per event channel; sampled when its strobe is high.
- hold_i  in  N_SRC  debounced held-button levels.
- hold_cmd_i  in  N_SRC*CMD_W  code per hold channel.
- tmr_period_i  in  N_TMR*TMR_W  period per timer; 0 disables that timer.
- tmr_cmd_i  in  N_TMR*CMD_W  code per timer.
- cmd_valid_o  out  1  FIFO non-empty.
- cmd_o  out  CMD_W  FIFO head.
- cmd_ready_i  in  1  consumer accepts the head.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- coalesce_cnt_o  out  16  saturating count of merged requests.

Behaviour:
- Reset: asynchronous, active-low. All outputs, pending latches, timers, repeat counters and FIFO pointers go to 0.
- Request lines: R = N_EV + N_SRC + N_TMR. Priority index order is events 0..N_EV-1, then holds, then timers. The lowest index wins.
- Event request: ev_valid_i[k] high in cycle t, with enable_i high.
- Hold request:
  - Press edge: hold_i[k] high and previous-cycle sample low.
  - Auto-repeat, only if REPEAT_EN[k]: a per-channel counter starts at 0 on the press edge. It fires when it reaches DAS_DELAY, then every DAS_RATE cycles while hold_i[k] stays high.
  - Release clears the counter. Re-press restarts the full DAS_DELAY.
- Timer request:
  - The counter increments each enabled cycle.
  - When counter >= period-1, it requests and reloads 0. Using >= means shrinking the period mid-count fires next cycle.
  - Period 0: counter held at 0, no requests.
- Pending latch: one per line, holding the valid bit and the code captured at request time.
  - A request in cycle t sets the latch at the edge ending t.
  - Set wins over a same-cycle grant-clear, so a new request is queued, not lost.
  - A request to a line whose latch is set and not granted this cycle is merged: the code is overwritten with the newest, and coalesce_cnt_o increments, saturating at 16'hFFFF.
- Arbiter: each cycle, grant the lowest-index set latch if FIFO push is allowed. At most one push per cycle.
  - Push allowed: level < DEPTH, or a pop happens this cycle.
  - When full, latches hold; nothing is dropped except by coalescing.
- Latency: a request in cycle t with an empty FIFO and no higher-priority pending line shows cmd_valid_o=1 and cmd_o=code in cycle t+2.
- FIFO:
  - Show-ahead: cmd_o is the head; it is don't-care but stable when empty.
  - Pop on cmd_valid_o & cmd_ready_i.
  - Push and pop in the same cycle leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - level_o is exact; it is registered and updated the same edge as the push or pop.
- enable_i low:
  - No new requests are generated.
  - Timer and repeat counters are held at 0.
  - The hold edge detector keeps sampling, so a button held across enable rising does not produce a press.
  - Pending latches still drain into the FIFO, and the consumer may still pop.
- flush_i high in a cycle: at that edge, clears the FIFO (level 0), all latches, and timer and repeat counters.
  - Requests in the same cycle are discarded.
  - A same-cycle pop is ignored.
  - coalesce_cnt_o is retained; only reset clears it.
- Reset assertion mid-operation abandons everything immediately. After deassertion, the first requests are accepted on the first clk edge.

Test Plan:
- Single event: ev_valid_i[0] pulse code 4'h3 at cycle 10, FIFO empty, ready=0 -> cmd_valid_o=1, cmd_o=3 at cycle 12, level_o=1.
- Priority: all lines request in one cycle (N_EV=2, N_SRC=4, N_TMR=2) -> 8 entries emitted in index order ev0, ev1, hold0..3, tmr0, tmr1; coalesce_cnt_o=0.
- Auto-repeat (DAS_DELAY=10, DAS_RATE=4): hold_i[1] high for 30 cycles -> requests at press+0, +10, +14, +18, +22, +26; release then re-press -> next repeat only at +10 after the new press.
- Full and coalesce (DEPTH=4, ready=0): 4 events fill the FIFO; ev1 pulses three more times -> level_o=4, latch holds the last code, coalesce_cnt_o=2. Then raise ready -> the latched code appears 5th.
- Timer: period 5, enable 40 cycles -> exactly 8 requests, 5 cycles apart. Period changed to 2 while the counter is at 3 -> fires the next cycle. Period 0 -> no requests.
- Flush and reset: flush_i pulse with level 3 and ready=1 -> level_o=0 next cycle, cmd_valid_o=0, coalesce count unchanged. reset_n low mid-stream -> all outputs 0 asynchronously.
